// File: rtl/dmem_responder.sv
// Data-memory responder: 256 x 16 RAM serving the CPU MEM-stage data port,
// with a host request/acknowledge port (read, write, clear-all) that is
// serviced only while the CPU is held (enable low).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting; host request accepted only when enable=0
// S_CLEAR | sweeping cnt over the array, zeroing one word per enable-low cycle
// S_ACK   | one-cycle completion pulse on h_ack, then back to S_IDLE
module dmem_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_dataout,
  input  logic              d_we,
  output logic [DATA_W-1:0] d_datain,
  input  logic              h_req,
  input  logic              h_we,
  input  logic              h_clr,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic [DATA_W-1:0] h_rdata,
  output logic              h_ack,
  output logic              h_busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_ACK   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] h_rdata_q, h_rdata_d;

  logic [DATA_W-1:0] mem [DEPTH];

  // Single RAM write port: CPU stores only while enable=1, host writes only
  // while enable=0, so the two sources never collide.
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  // Host writes are also blocked in a reset cycle so an aborted clear stops
  // exactly where reset caught it.
  logic host_ok;

  assign host_ok  = !enable && !reset;
  assign d_datain = mem[d_addr];
  assign h_rdata  = h_rdata_q;
  assign h_ack    = (state_q == S_ACK);
  assign h_busy   = (state_q != S_IDLE);

  // Next-state, counter, read-data capture and RAM write-port selection.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    h_rdata_d = h_rdata_q;
    mem_we    = enable && d_we;
    mem_waddr = d_addr;
    mem_wdata = d_dataout;

    case (state_q)
      S_IDLE: begin
        if (host_ok && h_req) begin
          if (h_clr) begin
            cnt_d   = '0;
            state_d = S_CLEAR;
          end else if (h_we) begin
            mem_we    = 1'b1;
            mem_waddr = h_addr;
            mem_wdata = h_wdata;
            state_d   = S_ACK;
          end else begin
            h_rdata_d = mem[h_addr];
            state_d   = S_ACK;
          end
        end
      end
      S_CLEAR: begin
        if (host_ok) begin
          mem_we    = 1'b1;
          mem_waddr = cnt_q;
          mem_wdata = '0;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = S_ACK;
          end
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      h_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      h_rdata_q <= h_rdata_d;
    end
  end

  // RAM array write; contents survive reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: stimulus pushes expected h_ack
// cycle and read data into a scoreboard; a monitor pops on every h_ack.
module tb_dmem_responder;

  localparam int AW = 8;
  localparam int DW = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_dataout = '0;
  logic          d_we = 1'b0;
  logic [DW-1:0] d_datain;
  logic          h_req = 1'b0;
  logic          h_we = 1'b0;
  logic          h_clr = 1'b0;
  logic [AW-1:0] h_addr = '0;
  logic [DW-1:0] h_wdata = '0;
  logic [DW-1:0] h_rdata;
  logic          h_ack;
  logic          h_busy;

  dmem_responder #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .d_addr(d_addr), .d_dataout(d_dataout), .d_we(d_we), .d_datain(d_datain),
    .h_req(h_req), .h_we(h_we), .h_clr(h_clr), .h_addr(h_addr),
    .h_wdata(h_wdata), .h_rdata(h_rdata), .h_ack(h_ack), .h_busy(h_busy)
  );

  always #5 clock = ~clock;

  // cyc = number of rising edges so far; a request presented while cyc==c
  // is accepted at edge c+1 and acknowledged while cyc==c+1.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            cyc;
    bit            chk;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every h_ack must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && h_ack) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: h_ack=1 at cycle %0d with nothing expected", cyc);
      end else begin
        mon_e = sb.pop_front();
        if (cyc != mon_e.cyc) begin
          errors++;
          $display("FAIL ack_cycle: got cycle %0d expected cycle %0d", cyc, mon_e.cyc);
        end
        if (mon_e.chk) begin
          checks++;
          if (h_rdata !== mon_e.data) begin
            errors++;
            $display("FAIL ack_rdata: got %h expected %h (cycle %0d)", h_rdata, mon_e.data, cyc);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic start_req(input bit we, input bit clr, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input int extra, input bit chk,
                           input logic [DW-1:0] exp, input bit expect_ack);
    exp_t e;
    if (expect_ack) begin
      e.cyc  = cyc + 1 + extra;
      e.chk  = chk;
      e.data = exp;
      sb.push_back(e);
    end
    h_we    = we;
    h_clr   = clr;
    h_addr  = a;
    h_wdata = wd;
    h_req   = 1'b1;
  endtask

  task automatic wait_ack(input int limit, input string name);
    for (int i = 0; i < limit; i++) begin
      tick();
      if (h_ack) begin
        h_req = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL %s: no h_ack within %0d cycles", name, limit);
    h_req = 1'b0;
  endtask

  task automatic host_op(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                         input bit chk, input logic [DW-1:0] exp, input string name);
    start_req(we, 1'b0, a, wd, 0, chk, exp, 1'b1);
    wait_ack(20, name);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [AW-1:0] pre [4];
    int c;
    pre[0] = 8'h00; pre[1] = 8'h3F; pre[2] = 8'h80; pre[3] = 8'hFF;

    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("reset_rdata", h_rdata, 16'h0000);
    check("reset_ack", {15'd0, h_ack}, 16'h0000);
    check("reset_busy", {15'd0, h_busy}, 16'h0000);

    // Host write then read.
    host_op(1'b1, 8'h3C, 16'hBEEF, 1'b0, 16'h0000, "wr_3c");
    host_op(1'b0, 8'h3C, 16'h0000, 1'b1, 16'hBEEF, "rd_3c");
    d_addr = 8'h3C;
    #1 check("cpu_load_3c", d_datain, 16'hBEEF);

    // CPU store with enable high, then ignored store with enable low.
    enable = 1'b1; d_we = 1'b1; d_addr = 8'h05; d_dataout = 16'h1234;
    #1 check("cpu_same_cycle_old", d_datain === 16'h1234 ? 16'h0001 : 16'h0000, 16'h0000);
    tick();
    d_we = 1'b0;
    #1 check("cpu_store_05", d_datain, 16'h1234);
    enable = 1'b0; d_we = 1'b1; d_dataout = 16'h5678;
    tick();
    d_we = 1'b0;
    #1 check("cpu_store_blocked", d_datain, 16'h1234);

    // Host request blocked by enable for 10 cycles.
    enable = 1'b1;
    start_req(1'b0, 1'b0, 8'h05, 16'h0000, 10, 1'b1, 16'h1234, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("blocked_ack", {15'd0, h_ack}, 16'h0000);
      check("blocked_busy", {15'd0, h_busy}, 16'h0000);
    end
    enable = 1'b0;
    wait_ack(5, "blocked_rd");
    tick();

    // Clear with a 20-cycle enable pause mid-sweep.
    host_op(1'b1, 8'h00, 16'hFFFF, 1'b0, 16'h0000, "pre_00");
    host_op(1'b1, 8'h80, 16'hFFFF, 1'b0, 16'h0000, "pre_80");
    host_op(1'b1, 8'hFF, 16'hFFFF, 1'b0, 16'h0000, "pre_ff");
    start_req(1'b0, 1'b1, 8'h00, 16'h0000, 256 + 20, 1'b0, 16'h0000, 1'b1);
    repeat (100) tick();
    check("clear_busy", {15'd0, h_busy}, 16'h0001);
    enable = 1'b1;
    repeat (20) tick();
    check("clear_pause_busy", {15'd0, h_busy}, 16'h0001);
    enable = 1'b0;
    wait_ack(400, "clear_pause");
    tick();
    h_clr = 1'b0;
    check("rdata_hold", h_rdata, 16'h1234);
    host_op(1'b0, 8'h00, 16'h0000, 1'b1, 16'h0000, "rd_clr_00");
    host_op(1'b0, 8'h80, 16'h0000, 1'b1, 16'h0000, "rd_clr_80");
    host_op(1'b0, 8'hFF, 16'h0000, 1'b1, 16'h0000, "rd_clr_ff");

    // Reset while the sweep counter is at 0x40.
    for (int i = 0; i < 4; i++) host_op(1'b1, pre[i], 16'hFFFF, 1'b0, 16'h0000, "pre_rst");
    start_req(1'b0, 1'b1, 8'h00, 16'h0000, 0, 1'b0, 16'h0000, 1'b0);
    tick();
    h_req = 1'b0;
    h_clr = 1'b0;
    repeat (64) tick();
    check("rst_mid_busy_before", {15'd0, h_busy}, 16'h0001);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_busy", {15'd0, h_busy}, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rst_mid_noack", {15'd0, h_ack | h_busy}, 16'h0000);
    end
    for (int i = 0; i < 64; i++) begin
      d_addr = i[7:0];
      #1 check("rst_cleared", d_datain, 16'h0000);
    end
    d_addr = 8'h80;
    #1 check("rst_keep_80", d_datain, 16'hFFFF);
    d_addr = 8'hFF;
    #1 check("rst_keep_ff", d_datain, 16'hFFFF);
    tick();

    // Held request yields a second ack two cycles after the first.
    c = cyc;
    start_req(1'b0, 1'b0, 8'h80, 16'h0000, 0, 1'b1, 16'hFFFF, 1'b1);
    begin
      exp_t e2;
      e2.cyc = c + 3; e2.chk = 1'b1; e2.data = 16'hFFFF;
      sb.push_back(e2);
    end
    tick();
    check("held_ack1", {15'd0, h_ack}, 16'h0001);
    tick();
    check("held_gap", {15'd0, h_ack}, 16'h0000);
    tick();
    check("held_ack2", {15'd0, h_ack}, 16'h0001);
    h_req = 1'b0;
    repeat (5) tick();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected acks never seen, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
